bcd_converter_dd: RTL and testbench

Sequential double-dabble binary-to-BCD converter. Successor to the multi-state digit-by-digit converter: it adds synchronous reset, a ready/busy handshake, a signed-input mode, overflow detection with saturation, and a significant-digit count. All digits are adjusted in parallel, so each input bit costs one clock. It sits between binary datapath results and display/UART formatting logic.

---
 rtl/bcd_converter_dd.sv | 116 +++++++++++
 tb/tb_bcd_converter_dd.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bcd_converter_dd.sv
// Double-dabble binary-to-BCD converter: INPUT_WIDTH+2 cycles per conversion, one bit per clock.
// Start is taken only while o_Ready is high; requests made while busy are dropped, not queued.
module bcd_converter_dd #(
  parameter int INPUT_WIDTH    = 16,
  parameter int DECIMAL_DIGITS = 5,
  parameter int CNT_WIDTH      = $clog2(DECIMAL_DIGITS + 1)
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_L,
  input  logic                          i_Start,
  input  logic                          i_Signed,
  input  logic [INPUT_WIDTH-1:0]        i_Binary,
  output logic                          o_Ready,
  output logic [DECIMAL_DIGITS*4-1:0]   o_BCD,
  output logic                          o_Sign,
  output logic                          o_Overflow,
  output logic [CNT_WIDTH-1:0]          o_Digits,
  output logic                          o_DV
);

  localparam int BW = $clog2(INPUT_WIDTH + 1);
  localparam int DW = 4 * DECIMAL_DIGITS;
  localparam logic [INPUT_WIDTH-1:0] ONE      = INPUT_WIDTH'(1);
  localparam logic [DW-1:0]          ALL_NINE = {DECIMAL_DIGITS{4'h9}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    FINISH  = 2'd2
  } state_t;

  state_t                 state;
  logic [INPUT_WIDTH-1:0] mag;
  logic [DW-1:0]          bcd;
  logic [DW-1:0]          bcd_adj;
  logic                   sign_q;
  logic                   mag_zero;
  logic                   sticky;
  logic [BW-1:0]          bit_cnt;
  logic [CNT_WIDTH-1:0]   digits_calc;
  logic                   in_neg;
  logic [INPUT_WIDTH-1:0] in_mag;

  // The most negative input negates to itself, which read unsigned is 2^(INPUT_WIDTH-1).
  assign in_neg = i_Signed & i_Binary[INPUT_WIDTH-1];
  assign in_mag = in_neg ? (~i_Binary + ONE) : i_Binary;

  assign o_Ready = (state == IDLE);

  always_comb begin
    bcd_adj = '0;
    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
      bcd_adj[4*d +: 4] = (bcd[4*d +: 4] > 4'd4) ? (bcd[4*d +: 4] + 4'd3) : bcd[4*d +: 4];
    end
  end

  always_comb begin
    digits_calc = CNT_WIDTH'(1);
    for (int d = 0; d < DECIMAL_DIGITS; d++) begin
      if (bcd[4*d +: 4] != 4'd0) digits_calc = CNT_WIDTH'(d + 1);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Rst_L) begin
      state      <= IDLE;
      mag        <= '0;
      bcd        <= '0;
      sign_q     <= 1'b0;
      mag_zero   <= 1'b0;
      sticky     <= 1'b0;
      bit_cnt    <= '0;
      o_BCD      <= '0;
      o_Sign     <= 1'b0;
      o_Overflow <= 1'b0;
      o_Digits   <= '0;
      o_DV       <= 1'b0;
    end else begin
      o_DV <= 1'b0;
      case (state)
        IDLE: begin
          if (i_Start) begin
            mag      <= in_mag;
            sign_q   <= in_neg;
            mag_zero <= (in_mag == '0);
            bcd      <= '0;
            bit_cnt  <= '0;
            sticky   <= 1'b0;
            state    <= CONVERT;
          end
        end
        CONVERT: begin
          // A set top bit after adjustment is a carry out of the top digit: value no longer fits.
          bcd     <= {bcd_adj[DW-2:0], mag[INPUT_WIDTH-1]};
          mag     <= mag << 1;
          sticky  <= sticky | bcd_adj[DW-1];
          if (bit_cnt == BW'(INPUT_WIDTH - 1)) begin
            state <= FINISH;
          end else begin
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        FINISH: begin
          o_BCD      <= sticky ? ALL_NINE : bcd;
          o_Overflow <= sticky;
          o_Sign     <= sign_q & ~mag_zero;
          o_Digits   <= sticky ? CNT_WIDTH'(DECIMAL_DIGITS) : digits_calc;
          o_DV       <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter_dd.sv
// Directed bench: default 5-digit converter and a 4-digit converter driven with identical stimulus.
module tb_bcd_converter_dd;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sgn   = 1'b0;
  logic [15:0] bin   = '0;

  logic        rdy, sign, ovf, dv;
  logic [19:0] bcd;
  logic [2:0]  dig;
  logic        rdy4, sign4, ovf4, dv4;
  logic [15:0] bcd4;
  logic [2:0]  dig4;

  always #5 clk = ~clk;

  bcd_converter_dd dut (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Signed(sgn), .i_Binary(bin),
    .o_Ready(rdy), .o_BCD(bcd), .o_Sign(sign), .o_Overflow(ovf), .o_Digits(dig), .o_DV(dv)
  );

  bcd_converter_dd #(.INPUT_WIDTH(16), .DECIMAL_DIGITS(4)) dut4 (
    .i_Clock(clk), .i_Rst_L(rst_n), .i_Start(start), .i_Signed(sgn), .i_Binary(bin),
    .o_Ready(rdy4), .o_BCD(bcd4), .o_Sign(sign4), .o_Overflow(ovf4), .o_Digits(dig4), .o_DV(dv4)
  );

  typedef struct {
    logic        s;
    logic [15:0] b;
    logic [19:0] e_bcd;
    logic        e_sign;
    logic        e_ovf;
    logic [2:0]  e_dig;
    logic [15:0] e_bcd4;
    logic        e_ovf4;
    logic [2:0]  e_dig4;
  } vec_t;

  vec_t vecs[11];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns the number of edges after the accept edge at which o_DV became visible.
  task automatic run_conv(input logic s, input logic [15:0] b, output int lat);
    @(negedge clk);
    chk("ready_before_start", rdy, 1);
    start = 1'b1; sgn = s; bin = b;
    @(negedge clk);
    start = 1'b0; sgn = ~s; bin = ~b;
    chk("busy_after_accept", rdy, 0);
    lat = 0;
    while (!dv && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  logic [15:0] hold_vals [3];
  logic [19:0] hold_bcd  [3];
  logic [2:0]  hold_dig  [3];

  initial begin
    int lat;
    int n;
    logic seen;

    //           s     b          bcd5        sgn   ovf   dig   bcd4      ovf4  dig4
    vecs[0]  = '{1'b0, 16'h04D2, 20'h01234, 1'b0, 1'b0, 3'd4, 16'h1234, 1'b0, 3'd4};
    vecs[1]  = '{1'b1, 16'h8000, 20'h32768, 1'b1, 1'b0, 3'd5, 16'h9999, 1'b1, 3'd4};
    vecs[2]  = '{1'b1, 16'hFFFF, 20'h00001, 1'b1, 1'b0, 3'd1, 16'h0001, 1'b0, 3'd1};
    vecs[3]  = '{1'b0, 16'h0000, 20'h00000, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0, 3'd1};
    vecs[4]  = '{1'b1, 16'h0000, 20'h00000, 1'b0, 1'b0, 3'd1, 16'h0000, 1'b0, 3'd1};
    vecs[5]  = '{1'b0, 16'hFFFF, 20'h65535, 1'b0, 1'b0, 3'd5, 16'h9999, 1'b1, 3'd4};
    vecs[6]  = '{1'b1, 16'h7FFF, 20'h32767, 1'b0, 1'b0, 3'd5, 16'h9999, 1'b1, 3'd4};
    vecs[7]  = '{1'b1, 16'hFF85, 20'h00123, 1'b1, 1'b0, 3'd3, 16'h0123, 1'b0, 3'd3};
    vecs[8]  = '{1'b0, 16'h8000, 20'h32768, 1'b0, 1'b0, 3'd5, 16'h9999, 1'b1, 3'd4};
    vecs[9]  = '{1'b0, 16'h270F, 20'h09999, 1'b0, 1'b0, 3'd4, 16'h9999, 1'b0, 3'd4};
    vecs[10] = '{1'b0, 16'h2710, 20'h10000, 1'b0, 1'b0, 3'd5, 16'h9999, 1'b1, 3'd4};

    hold_vals[0] = 16'd5;    hold_bcd[0] = 20'h00005; hold_dig[0] = 3'd1;
    hold_vals[1] = 16'd42;   hold_bcd[1] = 20'h00042; hold_dig[1] = 3'd2;
    hold_vals[2] = 16'd999;  hold_bcd[2] = 20'h00999; hold_dig[2] = 3'd3;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ready", rdy, 1);
    chk("reset_bcd", bcd, 0);
    chk("reset_digits", dig, 0);
    chk("reset_dv", dv, 0);
    chk("reset_misc", {sign, ovf, sign4, ovf4, dv4}, 0);

    for (int i = 0; i < 11; i++) begin
      run_conv(vecs[i].s, vecs[i].b, lat);
      chk($sformatf("v%0d_latency", i), lat, 17);
      chk($sformatf("v%0d_bcd", i), bcd, vecs[i].e_bcd);
      chk($sformatf("v%0d_sign", i), sign, vecs[i].e_sign);
      chk($sformatf("v%0d_ovf", i), ovf, vecs[i].e_ovf);
      chk($sformatf("v%0d_digits", i), dig, vecs[i].e_dig);
      chk($sformatf("v%0d_dv4", i), dv4, 1);
      chk($sformatf("v%0d_bcd4", i), bcd4, vecs[i].e_bcd4);
      chk($sformatf("v%0d_sign4", i), sign4, vecs[i].e_sign);
      chk($sformatf("v%0d_ovf4", i), ovf4, vecs[i].e_ovf4);
      chk($sformatf("v%0d_digits4", i), dig4, vecs[i].e_dig4);
      @(negedge clk);
      chk($sformatf("v%0d_dv_one_cycle", i), dv, 0);
      chk($sformatf("v%0d_bcd_held", i), bcd, vecs[i].e_bcd);
    end

    // Start held high throughout: only IDLE may accept, inputs scrambled while busy.
    @(negedge clk);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sgn = 1'b0;
      bin = hold_vals[k];
      @(negedge clk);
      sgn = 1'b1;
      bin = 16'hA5A5;
      n = 0;
      while (!dv && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (k == 0) chk("hold_first_latency", n, 17);
      else        chk($sformatf("hold_period_%0d", k), n + 1, 18);
      chk($sformatf("hold_bcd_%0d", k), bcd, hold_bcd[k]);
      chk($sformatf("hold_digits_%0d", k), dig, hold_dig[k]);
      chk($sformatf("hold_sign_%0d", k), sign, 0);
    end
    start = 1'b0;
    @(negedge clk);
    chk("hold_dv_low", dv, 0);

    // Reset asserted during the 8th CONVERT cycle aborts the conversion.
    @(negedge clk);
    start = 1'b1; sgn = 1'b0; bin = 16'd4321;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_ready", rdy, 1);
    chk("abort_bcd", bcd, 0);
    chk("abort_digits", dig, 0);
    chk("abort_flags", {sign, ovf, dv}, 0);
    chk("abort_bcd4", bcd4, 0);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (dv || dv4) seen = 1'b1;
    end
    chk("abort_no_dv", seen, 0);

    run_conv(1'b0, 16'd321, lat);
    chk("post_abort_latency", lat, 17);
    chk("post_abort_bcd", bcd, 20'h00321);
    chk("post_abort_digits", dig, 3);
    chk("post_abort_bcd4", bcd4, 16'h0321);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
